// File: rtl/chain_score_pipe.sv
// Six-register valid/ready pipeline that scores one (predecessor j, current i) anchor pair per cycle.
// A single global advance signal stalls every stage together, so pair order is preserved.
module chain_score_pipe #(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int CW   = 24,
  parameter int TAGW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  ri_x,
  input  logic signed [W-1:0]  ri_y,
  input  logic signed [W-1:0]  qi_x,
  input  logic signed [W-1:0]  qi_y,
  input  logic [TAGW-1:0]      in_tag,
  input  logic signed [W-1:0]  cfg_q_span,
  input  logic signed [W-1:0]  cfg_max_dist,
  input  logic [CW-1:0]        cfg_gap_coef,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  out_score,
  output logic                 out_pass,
  output logic [TAGW-1:0]      out_tag
);

  localparam int LGW = $clog2(W + 1);
  localparam int PW  = W + 1 + CW;
  localparam int NW  = W + CW;
  localparam int DW  = W + CW + 2;
  localparam logic [W-1:0] NEG_INF = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

  // Index of the most significant set bit; zero maps to zero.
  function automatic logic [LGW-1:0] ilog2_f(input logic [W:0] v);
    logic [LGW-1:0] r;
    r = '0;
    for (int k = 0; k <= W; k++) begin
      if (v[k]) r = LGW'(k);
      else      r = r;
    end
    return r;
  endfunction

  logic adv_s;
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // Stage registers
  logic                 v0_r, v1_r, v2_r, v3_r, v4_r;
  logic [TAGW-1:0]      tag0_r, tag1_r, tag2_r, tag3_r, tag4_r;
  logic signed [W-1:0]  rix_r, riy_r, qix_r, qiy_r;
  logic signed [W:0]    dr1_r, dq1_r;
  logic                 rej2_r, rej3_r, rej4_r;
  logic [W:0]           dd2_r;
  logic signed [W:0]    dg2_r, a3_r, a4_r;
  logic [PW-1:0]        prod3_r;
  logic [LGW-1:0]       lg3_r;
  logic                 dz3_r;
  logic [NW-1:0]        pen4_r;

  // Combinational stage results
  logic signed [W:0]    dr_s, dq_s;
  logic                 rej2_s, rej3_s;
  logic [W:0]           dd2_s;
  logic signed [W:0]    dg2_s, qs_ext_s, a3_s;
  logic [PW-1:0]        prod3_s;
  logic [LGW-1:0]       lg3_s;
  logic [NW-1:0]        pen4_s;
  logic signed [DW-1:0] diff_s;
  logic [W-1:0]         sat_s, score5_s;

  // Front half: coordinate differences, sign rejection, gap and diagonal terms
  always_comb begin
    dr_s   = $signed({rix_r[W-1], rix_r}) - $signed({riy_r[W-1], riy_r});
    dq_s   = $signed({qix_r[W-1], qix_r}) - $signed({qiy_r[W-1], qiy_r});
    rej2_s = dr1_r[W] || (dr1_r == '0) || dq1_r[W] || (dq1_r == '0);
    if (dr1_r >= dq1_r) begin
      dd2_s = $unsigned(dr1_r - dq1_r);
      dg2_s = dq1_r;
    end else begin
      dd2_s = $unsigned(dq1_r - dr1_r);
      dg2_s = dr1_r;
    end
  end

  // Back half: bandwidth rejection, capped match term, fixed-point penalty, saturating score
  always_comb begin
    rej3_s   = rej2_r || (dd2_r > {1'b0, cfg_max_dist});
    qs_ext_s = $signed({cfg_q_span[W-1], cfg_q_span});
    if (dg2_r < qs_ext_s) a3_s = dg2_r;
    else                  a3_s = qs_ext_s;
    prod3_s = PW'(dd2_r) * PW'(cfg_gap_coef);
    lg3_s   = ilog2_f(dd2_r);
    if (dz3_r) pen4_s = '0;
    else       pen4_s = NW'(prod3_r >> FRAC) + NW'(lg3_r >> 1);
    diff_s = $signed({{(DW-W-1){a4_r[W]}}, a4_r}) - $signed({2'b00, pen4_r});
    if (diff_s > $signed({{(DW-W){1'b0}}, POS_MAX}))      sat_s = POS_MAX;
    else if (diff_s < $signed({{(DW-W){1'b1}}, NEG_INF})) sat_s = NEG_INF;
    else                                                  sat_s = diff_s[W-1:0];
    if (rej4_r) score5_s = NEG_INF;
    else        score5_s = sat_s;
  end

  // Input capture, difference and gap stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_r <= 1'b0; tag0_r <= '0; rix_r <= '0; riy_r <= '0; qix_r <= '0; qiy_r <= '0;
      v1_r <= 1'b0; tag1_r <= '0; dr1_r <= '0; dq1_r <= '0;
      v2_r <= 1'b0; tag2_r <= '0; rej2_r <= 1'b0; dd2_r <= '0; dg2_r <= '0;
    end else if (adv_s) begin
      v0_r <= in_valid; tag0_r <= in_tag;
      rix_r <= ri_x; riy_r <= ri_y; qix_r <= qi_x; qiy_r <= qi_y;
      v1_r <= v0_r; tag1_r <= tag0_r; dr1_r <= dr_s; dq1_r <= dq_s;
      v2_r <= v1_r; tag2_r <= tag1_r; rej2_r <= rej2_s; dd2_r <= dd2_s; dg2_r <= dg2_s;
    end
  end

  // Product, penalty and output stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3_r <= 1'b0; tag3_r <= '0; rej3_r <= 1'b0; a3_r <= '0;
      prod3_r <= '0; lg3_r <= '0; dz3_r <= 1'b0;
      v4_r <= 1'b0; tag4_r <= '0; rej4_r <= 1'b0; a4_r <= '0; pen4_r <= '0;
      out_valid <= 1'b0; out_score <= '0; out_pass <= 1'b0; out_tag <= '0;
    end else if (adv_s) begin
      v3_r <= v2_r; tag3_r <= tag2_r; rej3_r <= rej3_s; a3_r <= a3_s;
      prod3_r <= prod3_s; lg3_r <= lg3_s; dz3_r <= (dd2_r == '0);
      v4_r <= v3_r; tag4_r <= tag3_r; rej4_r <= rej3_r; a4_r <= a3_r; pen4_r <= pen4_s;
      out_valid <= v4_r;
      out_score <= score5_s;
      out_pass  <= !rej4_r;
      out_tag   <= tag4_r;
    end
  end

endmodule

// File: tb/tb_chain_score_pipe.sv
// Directed bench for chain_score_pipe: hand-computed scores, rejects, saturation,
// backpressure ordering and mid-stream reset.
module tb_chain_score_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ri_x, ri_y, qi_x, qi_y;
  logic [7:0]  in_tag;
  logic [31:0] cfg_q_span, cfg_max_dist;
  logic [23:0] cfg_gap_coef;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_score;
  logic        out_pass;
  logic [7:0]  out_tag;

  int checks = 0;
  int fails  = 0;

  chain_score_pipe #(.W(32), .FRAC(16), .CW(24), .TAGW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ri_x(ri_x), .ri_y(ri_y), .qi_x(qi_x), .qi_y(qi_y), .in_tag(in_tag),
    .cfg_q_span(cfg_q_span), .cfg_max_dist(cfg_max_dist), .cfg_gap_coef(cfg_gap_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_score(out_score),
    .out_pass(out_pass), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Score for backpressure pair k: dr=100, dq=100+37k, so dd=37k and a=15.
  function automatic logic [31:0] bp_score(input int k);
    int dd, lg, v, pen;
    dd = 37 * k;
    lg = 0;
    v  = dd;
    while (v > 1) begin
      v = v / 2;
      lg++;
    end
    pen = (dd == 0) ? 0 : ((dd * 9830) / 65536 + lg / 2);
    return 32'(15 - pen);
  endfunction

  task automatic run_pair(input string name, input logic [31:0] rx, input logic [31:0] ry,
                          input logic [31:0] qx, input logic [31:0] qy, input logic [7:0] tag,
                          input logic [31:0] exp_score, input logic exp_pass);
    @(negedge clk);
    ri_x = rx; ri_y = ry; qi_x = qx; qi_y = qy; in_tag = tag; in_valid = 1'b1;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk({name, "_not_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_score"}, out_score, exp_score);
    chk({name, "_pass"}, {31'd0, out_pass}, {31'd0, exp_pass});
    chk({name, "_tag"}, {24'd0, out_tag}, {24'd0, tag});
    @(negedge clk);
    chk({name, "_alone"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, cyc;
    logic acc;
    logic [31:0] hold_score;
    logic [7:0]  hold_tag;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ri_x = 32'd0; ri_y = 32'd0; qi_x = 32'd0; qi_y = 32'd0; in_tag = 8'd0;
    cfg_q_span = 32'd15; cfg_max_dist = 32'd5000; cfg_gap_coef = 24'd9830;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_score", out_score, 32'd0);
    chk("rst_pass", {31'd0, out_pass}, 32'd0);
    chk("rst_tag", {24'd0, out_tag}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_pair("equal", 32'd1100, 32'd1000, 32'd600, 32'd500, 8'h11, 32'd15, 1'b1);
    run_pair("small", 32'd1100, 32'd1000, 32'd590, 32'd500, 8'h22, 32'd13, 1'b1);
    run_pair("large", 32'd2000, 32'd1000, 32'd510, 32'd500, 8'h33, -32'sd142, 1'b1);
    run_pair("rej_dq0", 32'd1100, 32'd1000, 32'd500, 32'd500, 8'h44, 32'h8000_0000, 1'b0);
    run_pair("rej_drneg", 32'd995, 32'd1000, 32'd600, 32'd500, 8'h45, 32'h8000_0000, 1'b0);
    run_pair("rej_dist", 32'd7100, 32'd1000, 32'd600, 32'd500, 8'h46, 32'h8000_0000, 1'b0);
    run_pair("dist_edge", 32'd6100, 32'd1000, 32'd600, 32'd500, 8'h47, -32'sd740, 1'b1);

    cfg_gap_coef = 24'hFF_FFFF; cfg_max_dist = 32'h7FFF_FFFF;
    run_pair("saturate", 32'h4000_0000, 32'd0, 32'd1, 32'd0, 8'h48, 32'h8000_0000, 1'b1);
    cfg_gap_coef = 24'd9830; cfg_max_dist = 32'd5000;

    // Backpressure: 20 back-to-back pairs, out_ready low for cycles 10..12.
    sent = 0; rcv = 0; cyc = 0;
    hold_score = 32'd0; hold_tag = 8'd0;
    while (rcv < 20 && cyc < 80) begin
      @(negedge clk);
      out_ready = !(cyc >= 10 && cyc <= 12);
      if (sent < 20) begin
        ri_x = 32'd1100; ri_y = 32'd1000;
        qi_x = 32'(600 + 37 * sent); qi_y = 32'd500;
        in_tag = 8'(sent); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, {31'd0, out_ready});
      if (!out_ready) begin
        chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
        if (cyc == 10) begin
          hold_score = out_score;
          hold_tag   = out_tag;
        end else begin
          chk("bp_hold_score", out_score, hold_score);
          chk("bp_hold_tag", {24'd0, out_tag}, {24'd0, hold_tag});
        end
      end
      if (out_valid && out_ready) begin
        chk("bp_tag_order", {24'd0, out_tag}, 32'(rcv));
        chk("bp_score", out_score, bp_score(rcv));
        chk("bp_pass", {31'd0, out_pass}, 32'd1);
        rcv++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    chk("bp_received", 32'(rcv), 32'd20);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_dup", {31'd0, out_valid}, 32'd0);
    end

    // Mid-stream reset with pairs still inside the pipeline.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ri_x = 32'd1100; ri_y = 32'd1000; qi_x = 32'd600; qi_y = 32'd500;
      in_tag = 8'(8'hA0 + k); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst_valid_now", {31'd0, out_valid}, 32'd0);
    chk("mrst_tag_now", {24'd0, out_tag}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (8) begin
      @(negedge clk);
      chk("mrst_flushed", {31'd0, out_valid}, 32'd0);
    end
    run_pair("after_rst", 32'd1100, 32'd1000, 32'd590, 32'd500, 8'h55, 32'd13, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/chain_score_pipe.md
# chain_score_pipe

Parametrised, handshaked successor to the anchor-pair chaining score unit. It scores one (predecessor j, current i) anchor pair per cycle using `score = min(min(dr,dq), q_span) - (floor(dd*gap_coef) + (ilog2(dd)>>1))`, where `dd = |dr-dq|`. Pairs that cannot chain are rejected and flagged. It uses fixed-point arithmetic in place of floating-point multipliers, carries a per-pair tag, and has valid/ready backpressure so it can sit between the anchor buffer and the chaining DP max-reduction tree.

## Interface
Parameters:
- `W`, 32: coordinate and score width (signed two's complement).
- `FRAC`, 16: fractional bits of `cfg_gap_coef`.
- `CW`, 24: width of `cfg_gap_coef` (unsigned Q(CW-FRAC).FRAC).
- `TAGW`, 8: width of the pass-through tag.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: input pair valid.
- `in_ready`, out, 1: block can accept this cycle.
- `ri_x`, `ri_y`, in, W each: reference positions of anchor i and anchor j (signed).
- `qi_x`, `qi_y`, in, W each: query positions of anchor i and anchor j (signed).
- `in_tag`, in, TAGW: opaque tag (predecessor index).
- `cfg_q_span`, in, W: minimizer span, the cap on the match term.
- `cfg_max_dist`, in, W: bandwidth; reject when dd exceeds it.
- `cfg_gap_coef`, in, CW: 0.01*avg_qspan in fixed point.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts.
- `out_score`, out, W: signed score, or NEG_INF on reject.
- `out_pass`, out, 1: 1 means the pair is chainable.
- `out_tag`, out, TAGW: tag of the result.

## Operation
- Transfer rules:
  - Input transfer happens when `in_valid && in_ready`.
  - Output transfer happens when `out_valid && out_ready`.
- Global-stall pipeline:
  - `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - All stages move only when `adv=1`.
  - Bubbles are not compressed.
- S1:
  - `dr = ri_x - ri_y` and `dq = qi_x - qi_y`, computed in W+1 bits signed.
  - Register tag and valid.
- S2:
  - `rej = (dr <= 0) || (dq <= 0)`.
  - `dd = |dr - dq|`, W+1 bits unsigned.
  - `dg = min(dr, dq)`.
- S3:
  - `rej |= (dd > cfg_max_dist)`, using an unsigned compare with `cfg_max_dist` zero-extended.
  - `a = min(dg, cfg_q_span)`.
  - `prod = dd * cfg_gap_coef`, W+1+CW bits.
  - `lg = ilog2(dd)`, the index of the MSB set; `ilog2(0) = 0`.
- S4:
  - `pen = (prod >> FRAC) + (lg >> 1)`, truncation toward zero.
  - `pen = 0` when `dd == 0`.
  - Compute in W+CW bits.
- S5 (output register):
  - `diff = a - pen`, wide signed, then saturated to the W-bit signed range.
  - `out_score = rej ? NEG_INF : diff`, where `NEG_INF = {1'b1, (W-1){1'b0}}`.
  - `out_pass = !rej`.
- Config inputs are quasi-static:
  - They may change only while the pipeline is empty (no valid in S1..S5).
  - Otherwise results are undefined.
- Reset behaviour:
  - Reset clears every stage valid, `out_valid=0`, `out_score=0`, `out_pass=0`, `out_tag=0`.
  - `in_ready=1` on the first cycle after reset deassertion.
  - Reset mid-stream drops all in-flight pairs, and no partial result appears afterward.

## Timing
- Latency is 5 cycles. A pair accepted at edge N appears with `out_valid=1` after edge N+5, given no stall.
- Throughput is 1 pair per cycle while `out_ready=1`.
- Stall behaviour:
  - When `out_valid && !out_ready`, `in_ready` drops combinationally.
  - All stage registers hold and the outputs stay stable.
  - Order is preserved, with no loss or duplication.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- All stage registers use async reset.

## Test plan
Unless stated, `cfg_gap_coef = 9830` (0.15, avg_qspan=15), `cfg_q_span = 15`, `cfg_max_dist = 5000`.
- **Equal gaps:** ri_x=1100, ri_y=1000, qi_x=600, qi_y=500 (dr=dq=100, dd=0) → 5 cycles later `out_score=15`, `out_pass=1`, tag echoed.
- **Small gap:** dr=100, dq=90 (dd=10) → penalty 1+1=2, `out_score=13`.
- **Large gap:** dr=1000, dq=10 (dd=990). `prod = 9731700 >> 16 = 148` and `ilog2 = 9 >> 1 = 4` → `out_score = 10 - 152 = -142`, `out_pass=1`.
- **Rejects:**
  - dq=0 → `out_score=0x80000000`, `out_pass=0`.
  - dr=-5 → `out_score=0x80000000`, `out_pass=0`.
  - dd=6000 with `cfg_max_dist=5000` → `out_score=0x80000000`, `out_pass=0`.
- **Backpressure:** stream 20 tagged pairs back-to-back and hold `out_ready` low for 3 cycles mid-stream → `in_ready` is low exactly those cycles, the output holds stable, and all 20 results arrive in tag order with no duplicates.
- **Mid-stream reset:** assert reset for 1 cycle with 4 pairs in flight → `out_valid=0` immediately. The next accepted pair emerges alone after 5 cycles with correct values.
